// File: rtl/tpum_xbox_seq.sv
// TPUM vector register file and xbox burst sequencer behind a one-wait-state APB slave.
// Optional macro TPUM_SLVERR_EN: report unmapped accesses and writes dropped while busy on apb_pslverr.
module tpum_xbox_seq #(
  parameter int VEC_W     = 1024,
  parameter int NUM_VREGS = 3,
  parameter int XADDR_W   = 14,
  parameter int APB_AW    = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               apb_psel,
  input  logic               apb_penable,
  input  logic               apb_pwrite,
  input  logic [APB_AW-1:0]  apb_paddr,
  input  logic [31:0]        apb_pwdata,
  output logic [31:0]        apb_prdata,
  output logic               apb_pready,
  output logic               apb_pslverr,
  output logic               pum_rd_from_xbox,
  output logic               pum_wr_to_xbox,
  output logic [XADDR_W-1:0] pum_xbox_addr,
  output logic [VEC_W-1:0]   pum_xbox_wdata,
  input  logic [VEC_W-1:0]   pum_xbox_rdata,
  input  logic               pum_xbox_rvalid,
  input  logic               pum_xbox_ack,
  output logic               tpum_irq
);

  localparam int WPV = VEC_W / 32;
  localparam int NW  = NUM_VREGS * WPV;
  localparam int IW  = APB_AW - 2;
  localparam int FW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int VB  = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [31:0]        r_vmem [NW];
  logic [1:0]         r_opCfg;
  logic               r_irqEn;
  logic [XADDR_W-1:0] r_xaddrCfg;
  logic [7:0]         r_firstCfg;
  logic [7:0]         r_lenCfg;
  logic [7:0]         r_k;
  logic               r_done;
  logic               r_err;
  logic               r_illegal;
  logic               r_pready;
  logic [31:0]        r_prdata;

  logic [IW-1:0]      w_idx;
  logic [IW-1:0]      w_off;
  logic [FW-1:0]      w_flat;
  logic               w_isVreg;
  logic               w_access;
  logic               w_rdPhase;
  logic               w_commit;
  logic               w_busy;
  logic               w_wrCtrl;
  logic               w_wrXaddr;
  logic               w_wrXfer;
  logic               w_wrStatus;
  logic               w_wrVreg;
  logic               w_start;
  logic               w_legal;
  logic [8:0]         w_vSum;
  logic [FW-1:0]      w_rowBase;
  logic [VEC_W-1:0]   w_row;
  logic               w_kInc;
  logic               w_rowLast;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_unused = ^apb_paddr[1:0];

  assign w_idx     = apb_paddr[APB_AW-1:2];
  assign w_off     = w_idx - IW'(VB);
  assign w_flat    = w_off[FW-1:0];
  assign w_isVreg  = (w_idx >= IW'(VB)) && (w_idx < IW'(VB + NW));
  assign w_access  = apb_psel & apb_penable;
  assign w_rdPhase = w_access & ~r_pready;
  assign w_commit  = w_access & r_pready & apb_pwrite;
  assign w_busy    = (r_state != S_IDLE);

  // Configuration and vreg writes land at the end of the ready cycle and only while idle.
  assign w_wrCtrl   = w_commit & ~w_busy & (w_idx == IW'(0));
  assign w_wrXaddr  = w_commit & ~w_busy & (w_idx == IW'(1));
  assign w_wrXfer   = w_commit & ~w_busy & (w_idx == IW'(2));
  assign w_wrStatus = w_commit & (w_idx == IW'(3));
  assign w_wrVreg   = w_commit & ~w_busy & w_isVreg;
  assign w_start    = w_wrCtrl & apb_pwdata[0];

  assign w_legal = ((apb_pwdata[2:1] == 2'b01) || (apb_pwdata[2:1] == 2'b10)) &&
                   (r_lenCfg != 8'd0) &&
                   (({1'b0, r_firstCfg} + {1'b0, r_lenCfg}) <= 9'(NUM_VREGS));

  assign w_vSum    = {1'b0, r_firstCfg} + {1'b0, r_k};
  assign w_rowBase = FW'(int'(w_vSum) * WPV);
  assign w_rowLast = ((r_k + 8'd1) == r_lenCfg);

  always_comb begin
    w_row = '0;
    for (int w = 0; w < WPV; w++) begin
      w_row[w*32 +: 32] = r_vmem[w_rowBase + FW'(w)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Request lines decode straight from the state so a reset drops them on the next cycle.
  always_comb begin
    w_nextState      = r_state;
    w_kInc           = 1'b0;
    pum_rd_from_xbox = 1'b0;
    pum_wr_to_xbox   = 1'b0;
    pum_xbox_addr    = '0;
    pum_xbox_wdata   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (!w_legal) begin
            w_nextState = S_DONE;
          end else if (apb_pwdata[2:1] == 2'b01) begin
            w_nextState = S_RD_REQ;
          end else begin
            w_nextState = S_WR;
          end
        end
      end
      S_RD_REQ: begin
        pum_rd_from_xbox = 1'b1;
        pum_xbox_addr    = r_xaddrCfg + XADDR_W'(r_k);
        w_nextState      = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        pum_xbox_addr = r_xaddrCfg + XADDR_W'(r_k);
        if (pum_xbox_rvalid) begin
          w_kInc      = 1'b1;
          w_nextState = w_rowLast ? S_DONE : S_RD_REQ;
        end
      end
      S_WR: begin
        pum_wr_to_xbox = 1'b1;
        pum_xbox_addr  = r_xaddrCfg + XADDR_W'(r_k);
        pum_xbox_wdata = w_row;
        if (pum_xbox_ack) begin
          w_kInc      = 1'b1;
          w_nextState = w_rowLast ? S_DONE : S_WR;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Row counter and sticky status; the sequencer setting DONE/ERR beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k       <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_start) begin
        r_k       <= '0;
        r_illegal <= ~w_legal;
      end else if (w_kInc) begin
        r_k <= r_k + 8'd1;
      end
      if (r_state == S_DONE) begin
        r_done <= 1'b1;
      end else if (w_start || (w_wrStatus && apb_pwdata[1])) begin
        r_done <= 1'b0;
      end
      if ((r_state == S_DONE) && r_illegal) begin
        r_err <= 1'b1;
      end else if (w_start || (w_wrStatus && apb_pwdata[2])) begin
        r_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opCfg    <= '0;
      r_irqEn    <= 1'b0;
      r_xaddrCfg <= '0;
      r_firstCfg <= '0;
      r_lenCfg   <= '0;
    end else begin
      if (w_wrCtrl) begin
        r_opCfg <= apb_pwdata[2:1];
        r_irqEn <= apb_pwdata[3];
      end
      if (w_wrXaddr) begin
        r_xaddrCfg <= apb_pwdata[XADDR_W-1:0];
      end
      if (w_wrXfer) begin
        r_firstCfg <= apb_pwdata[7:0];
        r_lenCfg   <= apb_pwdata[15:8];
      end
    end
  end

  // APB vreg writes and xbox row loads never coincide because APB writes are dropped while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) begin
        r_vmem[i] <= '0;
      end
    end else begin
      if (w_wrVreg) begin
        r_vmem[w_flat] <= apb_pwdata;
      end
      if ((r_state == S_RD_WAIT) && pum_xbox_rvalid) begin
        for (int w = 0; w < WPV; w++) begin
          r_vmem[w_rowBase + FW'(w)] <= pum_xbox_rdata[w*32 +: 32];
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_isVreg) begin
      w_rdata = r_vmem[w_flat];
    end else begin
      case (w_idx)
        IW'(0):  w_rdata = {28'b0, r_irqEn, r_opCfg, 1'b0};
        IW'(1):  w_rdata = 32'(r_xaddrCfg);
        IW'(2):  w_rdata = {16'b0, r_lenCfg, r_firstCfg};
        IW'(3):  w_rdata = {8'b0, r_k, 13'b0, r_err, r_done, w_busy};
        default: w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pready <= 1'b0;
      r_prdata <= '0;
    end else begin
      r_pready <= w_access & ~r_pready;
      r_prdata <= (w_rdPhase && !apb_pwrite) ? w_rdata : '0;
    end
  end

`ifdef TPUM_SLVERR_EN
  logic r_pslverr;
  logic w_unmapped;
  logic w_dropTarget;

  assign w_unmapped   = ~((w_idx < IW'(4)) || w_isVreg);
  assign w_dropTarget = (w_idx < IW'(3)) || w_isVreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pslverr <= 1'b0;
    end else begin
      r_pslverr <= w_rdPhase & (w_unmapped | (apb_pwrite & w_busy & w_dropTarget));
    end
  end

  assign apb_pslverr = r_pslverr;
`else
  assign apb_pslverr = 1'b0;
`endif

  assign apb_prdata = r_prdata;
  assign apb_pready = r_pready;
  assign tpum_irq   = r_done & r_irqEn;

endmodule

// File: doc/tpum_xbox_seq.md
# tpum_xbox_seq

Parametrised next-generation TPUM register-file/crossbar sequencer. It holds NUM_VREGS vector registers of VEC_W bits, each programmable word-by-word over APB. An APB-triggered FSM moves a burst of up to NUM_VREGS rows between the vector registers and the xbox memory with a real read/write handshake, then reports done/error status and an optional interrupt. It sits between the RISC-V APB fabric and the xbox array, replacing the fixed three-register, non-sequenced TPUM front end.

## Interface
- VEC_W, 1024, vector/xbox row width; multiple of 32
- NUM_VREGS, 3, number of vector registers (≤255)
- XADDR_W, 14, xbox row address width
- APB_AW, 12, APB address width; word index = paddr[APB_AW-1:2]

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- apb_psel / apb_penable / apb_pwrite  in  1  APB control
- apb_paddr  in  APB_AW  byte address, 4-byte aligned
- apb_pwdata  in  32  write data
- apb_prdata  out  32  read data, valid while apb_pready=1
- apb_pready  out  1  transfer complete
- apb_pslverr  out  1  error response (see Configuration)
- pum_rd_from_xbox  out  1  one-cycle row read request
- pum_wr_to_xbox  out  1  row write request, held until ack
- pum_xbox_addr  out  XADDR_W  row address
- pum_xbox_wdata  out  VEC_W  row write data
- pum_xbox_rdata  in  VEC_W  row read data
- pum_xbox_rvalid  in  1  rdata valid
- pum_xbox_ack  in  1  write accepted
- tpum_irq  out  1  level interrupt = DONE & IRQ_EN

## Operation
Register map (word index):
- 0 CTRL: bit0 START (write-1, self-clearing, reads 0); [2:1] OP (01 LOAD, 10 STORE); bit3 IRQ_EN.
- 1 XADDR: [XADDR_W-1:0] first xbox row.
- 2 XFER: [7:0] FIRST vreg; [15:8] LEN rows.
- 3 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERR (W1C); [23:16] rows completed (RO).
- 64 + v·WPV + w (WPV = VEC_W/32): word w of vreg v; word 0 = bits [31:0].
- Unmapped reads return 0; unmapped writes are dropped.

FSM states: IDLE, RD_REQ, RD_WAIT, WR, DONE.
- IDLE: START write with BUSY=0 clears DONE/ERR/count and latches OP, XADDR, FIRST, LEN.
- Illegal start (OP ∉ {01,10}, LEN=0, or FIRST+LEN > NUM_VREGS) goes to DONE with ERR=1. No xbox traffic.
- LOAD: RD_REQ drives pum_rd_from_xbox=1 for one cycle with addr = XADDR+k, then enters RD_WAIT. In RD_WAIT, the first rvalid writes rdata into vreg[FIRST+k] and increments k; go to DONE if k=LEN, else RD_REQ.
- STORE: WR drives pum_wr_to_xbox=1, addr = XADDR+k, wdata = vreg[FIRST+k]. These hold stable until ack; on ack, increment k; go to DONE if k=LEN, else WR (wr stays high across rows).
- DONE: sets DONE for one cycle, then returns to IDLE.
- Address arithmetic wraps modulo 2^XADDR_W.
- rvalid outside RD_WAIT and ack outside WR are ignored.
- pum_xbox_wdata is 0 whenever not in WR.
- While BUSY: START is ignored. APB writes to CTRL/XADDR/XFER/vreg space are dropped. Reads are allowed, and vreg reads return current contents.
- Same cycle as a DONE W1C write while the FSM sets DONE: the set wins.

## Timing
- APB: one wait state. apb_pready <= access & !apb_pready, where access = psel & penable.
- Writes commit, and prdata is registered, in the cycle apb_pready=1.
- Reset values: apb_prdata=0, apb_pready=0, apb_pslverr=0, pum_rd_from_xbox=0, pum_wr_to_xbox=0, pum_xbox_addr=0, pum_xbox_wdata=0, tpum_irq=0.
- Reset also clears all registers and vregs and puts the FSM in IDLE.
- Reset mid-burst aborts immediately; the xbox sees request lines drop the next cycle.
- START committed at cycle T: BUSY=1 at T+1, and the first RD_REQ/WR is at T+1.
- LOAD with rvalid one cycle after each request: 2·LEN cycles of transfer, then DONE. DONE is visible in STATUS from T+2·LEN+2.
- STORE with ack in the first WR cycle: 1 cycle per row.
- Illegal start: DONE=ERR=1 visible at T+2.

## Configuration
- TPUM_SLVERR_EN defined: apb_pslverr=1, coincident with apb_pready, on:
  - any access to an unmapped index;
  - any dropped write while BUSY.
  Register state is unchanged.
- TPUM_SLVERR_EN undefined: apb_pslverr is tied to 0.

## Test plan
- Write 0xA5A5_0000+w to all words of vreg 1 via APB, read back -> each word matches; vreg 0/2 remain 0.
- XADDR=0x10, XFER FIRST=0 LEN=3, CTRL=0x3 (LOAD), model returns rdata=row pattern with rvalid after 1 cycle -> rd pulses at rows 0x10..0x12; vregs 0..2 hold the patterns; STATUS=0x0003_0002.
- XADDR=0x3FFF, FIRST=1 LEN=2, STORE, ack delayed 3 cycles per row -> wr held 4 cycles per row; addr 0x3FFF then 0x0000; wdata = vreg1 then vreg2.
- CTRL with OP=11, or FIRST=2 LEN=2 -> no xbox request; STATUS=0x6 at T+2; IRQ_EN=1 gives tpum_irq=1 until DONE W1C.
- During a LOAD, APB write to vreg word and second START -> dropped; pslverr=1 only with TPUM_SLVERR_EN; burst completes unchanged.
- Assert rst mid-STORE -> next cycle wr=0, addr=0, BUSY=0, vregs 0.
